// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states and width helpers for the band convolution
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sum_w(input int pix_w, input int k);
        return pix_w + clog2(k * k + 1);
    endfunction

    // counter width that never collapses to zero bits
    function automatic int cnt_w(input int n);
        return n > 1 ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_row_mac.sv
// conv_row_mac: one lane, accumulates one gated/signed kernel row per enabled cycle
module conv_row_mac
    import conv_pkg::*;
#(
    parameter int K = 5,
    parameter int PIX_W = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix [K],
    input  logic [K-1:0]     wt,
    input  logic             mode,
    input  logic             clr,
    input  logic             en,
    output logic [ACC_W-1:0] nxt
);

    logic [ACC_W-1:0] acc;

    always_comb begin
        nxt = acc;
        for (int j = 0; j < K; j++)
            nxt = wt[j] ? nxt + ACC_W'(pix[j]) : mode ? nxt - ACC_W'(pix[j]) : nxt;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= nxt;

endmodule

// File: rtl/conv_band_slide_p.sv
// conv_band_slide_p: K x K binary-weight sliding convolution over one band,
// LANES MAC lanes time-multiplexed across all window positions
module conv_band_slide_p
    import conv_pkg::*;
#(
    parameter int IMG_W = 12,
    parameter int K = 5,
    parameter int PIX_W = 4,
    parameter int STRIDE = 1,
    parameter int LANES = 8,
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
    localparam int OUT_BITS = sum_w(PIX_W, K) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_flag,
    input  logic [K*IMG_W*PIX_W-1:0]  in,
    input  logic [K*K-1:0]            filter,
    input  logic                      mode,
    output logic                      busy,
    output logic [OUT_W*OUT_BITS-1:0] out,
    output logic                      end_flag
);

    localparam int P = (OUT_W + LANES - 1) / LANES;
    localparam int RW = cnt_w(K);
    localparam int PW = cnt_w(P);

    if ((IMG_W - K) % STRIDE != 0) begin : g_bad_stride
        $error("conv_band_slide_p: (IMG_W-K) must be a multiple of STRIDE");
    end
    if (LANES < 1 || LANES > OUT_W) begin : g_bad_lanes
        $error("conv_band_slide_p: LANES must be within 1..OUT_W");
    end

    state_t            state;
    logic [RW-1:0]     row;
    logic [PW-1:0]     pass;
    logic              accept, last, clr, en, mode_q;
    logic [PIX_W-1:0]  band [K][IMG_W];
    logic [K-1:0]      frow [K];
    logic [K-1:0]      wt_row;
    logic [PIX_W-1:0]  cur [IMG_W];
    logic [PIX_W-1:0]  cand [LANES][P][K];
    logic [PIX_W-1:0]  lane_pix [LANES][K];
    logic [OUT_BITS-1:0] nxt [LANES];
    logic [OUT_BITS-1:0] shadow [OUT_W];

    assign accept = state == IDLE && start_flag && !busy;
    assign last   = state == MAC && row == RW'(K - 1);
    assign clr    = state == LOAD || last;
    assign en     = state == MAC;
    assign cur    = band[row];
    assign wt_row = frow[row];

    always_ff @(posedge clk)
        if (accept) begin
            mode_q <= mode;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < IMG_W; c++)
                    band[r][c] <= in[K*IMG_W*PIX_W-1-(r*IMG_W+c)*PIX_W -: PIX_W];
                for (int j = 0; j < K; j++)
                    frow[r][j] <= filter[K*K-1-(r*K+j)];
            end
        end

    // lanes past the last window see zeros; their results are never stored
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar p = 0; p < P; p++) begin : g_pass
            for (genvar j = 0; j < K; j++) begin : g_tap
                if (p * LANES + l < OUT_W) begin : g_live
                    assign cand[l][p][j] = cur[(p*LANES+l)*STRIDE+j];
                end else begin : g_idle
                    assign cand[l][p][j] = '0;
                end
            end
        end
        for (genvar j = 0; j < K; j++) begin : g_sel
            assign lane_pix[l][j] = cand[l][pass][j];
        end
        conv_row_mac #(.K(K), .PIX_W(PIX_W), .ACC_W(OUT_BITS)) u_mac (
            .clk   (clk),
            .reset (reset),
            .pix   (lane_pix[l]),
            .wt    (wt_row),
            .mode  (mode_q),
            .clr   (clr),
            .en    (en),
            .nxt   (nxt[l])
        );
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int s = 0; s < OUT_W; s++) shadow[s] <= '0;
        end else if (last) begin
            for (int s = 0; s < OUT_W; s++)
                if (pass == PW'(s / LANES)) shadow[s] <= nxt[s % LANES];
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            end_flag <= 1'b0;
            out      <= '0;
            row      <= '0;
            pass     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    end_flag <= 1'b0;
                    if (accept) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    row   <= '0;
                    pass  <= '0;
                    state <= MAC;
                end
                MAC: begin
                    if (row == RW'(K - 1)) begin
                        row <= '0;
                        if (pass == PW'(P - 1)) state <= DONE;
                        else pass <= pass + PW'(1);
                    end else row <= row + RW'(1);
                end
                DONE: begin
                    for (int s = 0; s < OUT_W; s++)
                        out[(OUT_W-1-s)*OUT_BITS +: OUT_BITS] <= shadow[s];
                    end_flag <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_conv_band_slide_p.sv
// tb_conv_band_slide_p: directed checks of the band convolution on three parameter sets
module tb_conv_band_slide_p;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic st_a = 1'b0, m_a = 1'b0, busy_a, ef_a;
    logic [239:0] in_a = '0;
    logic [24:0]  f_a = '0;
    logic [79:0]  out_a;

    logic st_b = 1'b0, m_b = 1'b0, busy_b, ef_b;
    logic [239:0] in_b = '0;
    logic [24:0]  f_b = '0;
    logic [79:0]  out_b;

    logic st_c = 1'b0, m_c = 1'b0, busy_c, ef_c;
    logic [259:0] in_c = '0;
    logic [24:0]  f_c = '0;
    logic [49:0]  out_c;

    conv_band_slide_p dut_a (
        .clk(clk), .reset(reset), .start_flag(st_a), .in(in_a), .filter(f_a),
        .mode(m_a), .busy(busy_a), .out(out_a), .end_flag(ef_a));

    conv_band_slide_p #(.LANES(3)) dut_b (
        .clk(clk), .reset(reset), .start_flag(st_b), .in(in_b), .filter(f_b),
        .mode(m_b), .busy(busy_b), .out(out_b), .end_flag(ef_b));

    conv_band_slide_p #(.IMG_W(13), .STRIDE(2), .LANES(2)) dut_c (
        .clk(clk), .reset(reset), .start_flag(st_c), .in(in_c), .filter(f_c),
        .mode(m_c), .busy(busy_c), .out(out_c), .end_flag(ef_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        int          v;
        logic [24:0] f;
        logic        m;
        int          base;
        int          step;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix(input int kind, input int v, input int r, input int c);
        return kind == 0 ? v : (r + c) % 16;
    endfunction

    function automatic logic [259:0] mk(input int kind, input int v, input int imgw);
        logic [259:0] b;
        b = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < imgw; c++)
                b[(5*imgw-1-(r*imgw+c))*4 +: 4] = 4'(pix(kind, v, r, c));
        return b;
    endfunction

    function automatic int model(input int kind, input int v, input int imgw, input int stride,
                                 input logic [24:0] f, input logic m, input int w);
        int s, p;
        s = 0;
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < 5; j++) begin
                p = pix(kind, v, r, w * stride + j);
                s += f[24-(r*5+j)] ? p : (m ? -p : 0);
            end
        return s;
    endfunction

    function automatic int slot(input int inst, input int w);
        logic [9:0] s;
        s = inst == 0 ? out_a[(7-w)*10 +: 10] : inst == 1 ? out_b[(7-w)*10 +: 10] : out_c[(4-w)*10 +: 10];
        return int'($signed(s));
    endfunction

    function automatic logic ef(input int inst);
        return inst == 0 ? ef_a : inst == 1 ? ef_b : ef_c;
    endfunction

    // drive one start pulse and count edges from the accepting edge to end_flag
    task automatic run(input int inst, input logic [259:0] b, input logic [24:0] f,
                       input logic m, output int lat);
        @(negedge clk);
        case (inst)
            0: begin in_a = b[239:0]; f_a = f; m_a = m; st_a = 1'b1; end
            1: begin in_b = b[239:0]; f_b = f; m_b = m; st_b = 1'b1; end
            default: begin in_c = b; f_c = f; m_c = m; st_c = 1'b1; end
        endcase
        @(negedge clk);
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (ef(inst)) begin lat = n; break; end
        end
    endtask

    task automatic chk_model(input int inst, input int outw, input int kind, input int v,
                             input int imgw, input int stride, input logic [24:0] f, input logic m);
        for (int w = 0; w < outw; w++)
            chk($sformatf("inst%0d slot%0d mode%0d", inst, w, m), slot(inst, w),
                model(kind, v, imgw, stride, f, m, w));
    endtask

    initial begin
        int lat, cnt;
        logic [24:0] rf;
        tv[0]  = '{0, 15, 25'h1FFFFFF, 1'b0, 375, 0};
        tv[1]  = '{0, 15, 25'h0000000, 1'b1, -375, 0};
        tv[2]  = '{0, 15, 25'h0000000, 1'b0, 0, 0};
        tv[3]  = '{0, 1, 25'h1555555, 1'b0, 13, 0};
        tv[4]  = '{0, 1, 25'h1555555, 1'b1, 1, 0};
        tv[5]  = '{0, 7, 25'h0000001, 1'b1, -161, 0};
        tv[6]  = '{1, 0, 25'h1FFFFFF, 1'b0, 100, 25};
        tv[7]  = '{1, 0, 25'h0000000, 1'b1, -100, -25};
        tv[8]  = '{1, 0, 25'h1000000, 1'b0, 0, 1};
        tv[9]  = '{1, 0, 25'h0000001, 1'b0, 8, 1};
        tv[10] = '{1, 0, 25'h0000001, 1'b1, -84, -23};

        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy_a), 0);
        chk("reset end_flag", int'(ef_a), 0);
        chk("reset out", int'(out_a != '0), 0);
        reset = 1'b0;

        foreach (tv[i]) begin
            run(0, mk(tv[i].kind, tv[i].v, 12), tv[i].f, tv[i].m, lat);
            chk($sformatf("vec%0d latency", i), lat, 7);
            chk($sformatf("vec%0d busy at end", i), int'(busy_a), 0);
            for (int w = 0; w < 8; w++)
                chk($sformatf("vec%0d slot%0d", i, w), slot(0, w), tv[i].base + tv[i].step * w);
        end
        @(posedge clk); #1;
        chk("end_flag pulse width", int'(ef_a), 0);

        // LANES=3: three passes, random weights in both modes
        for (int md = 0; md < 2; md++) begin
            rf = 25'($urandom);
            run(1, mk(1, 0, 12), rf, md[0], lat);
            chk("lanes3 latency", lat, 17);
            chk_model(1, 8, 1, 0, 12, 1, rf, md[0]);
            @(posedge clk); #1;
            chk("lanes3 pulse width", int'(ef_b), 0);
        end

        // start held across the busy window: one run, later inputs ignored
        @(negedge clk);
        in_a = mk(0, 15, 12); f_a = 25'h1FFFFFF; m_a = 1'b0; st_a = 1'b1;
        @(negedge clk);
        in_a = mk(0, 1, 12); m_a = 1'b1;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 4) st_a = 1'b0;
            if (ef_a) begin lat = n; break; end
        end
        chk("held start latency", lat, 7);
        chk("held start slot0", slot(0, 0), 375);
        chk("held start slot7", slot(0, 7), 375);
        @(posedge clk); #1;
        chk("no rerun busy", int'(busy_a), 0);

        // back-to-back: start in the end_flag cycle, out holds until next end_flag
        run(0, mk(0, 15, 12), 25'h1FFFFFF, 1'b0, lat);
        chk("b2b first latency", lat, 7);
        @(negedge clk);
        in_a = mk(0, 2, 12); st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        chk("b2b busy after accept", int'(busy_a), 1);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (ef_a) begin lat = n; break; end
            chk("b2b out stable", slot(0, 0), 375);
        end
        chk("b2b second latency", lat, 7);
        chk("b2b second slot3", slot(0, 3), 50);

        // reset during MAC row 2
        @(negedge clk);
        in_a = mk(0, 15, 12); st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", int'(busy_a), 0);
        chk("abort out", int'(out_a != '0), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ef_a) cnt++;
        end
        chk("abort no end_flag", cnt, 0);

        // IMG_W=13, STRIDE=2, LANES=2
        run(2, mk(0, 15, 13), 25'h1FFFFFF, 1'b0, lat);
        chk("stride2 latency", lat, 17);
        for (int w = 0; w < 5; w++)
            chk($sformatf("stride2 slot%0d", w), slot(2, w), 375);
        rf = 25'($urandom);
        run(2, mk(1, 0, 13), rf, 1'b1, lat);
        chk("stride2 ramp latency", lat, 17);
        chk_model(2, 5, 1, 0, 13, 2, rf, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
